// File: rtl/snn_pkg.sv
// Shared types and FP32 constants for the spiking-neuron potential update engine.
// Holds the FSM state encoding, FP32 field bounds and small classification helpers.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ADD,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [31:0] FP32_ZERO           = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN           = 32'h7FC0_0000;
    localparam logic [31:0] FP32_DEFAULT_THRESH = 32'h4220_0000;
    localparam logic [7:0]  EXP_MIN             = 8'h00;
    localparam logic [7:0]  EXP_MAX             = 8'hFF;

    function automatic logic fp32_is_nan(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic fp32_is_inf(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] == 23'd0);
    endfunction

endpackage

// File: rtl/lif_fp32_datapath.sv
// Combinational leaky-integrate-and-fire step on FP32 values:
// exponent-shift decay, add weight, strict threshold compare, subtract-on-spike.
module lif_fp32_datapath
    import snn_pkg::*;
#(
    parameter logic [31:0] V_THRESHOLD = FP32_DEFAULT_THRESH,
    parameter int          DECAY_SHIFT = 1
) (
    input  logic [31:0] pot_in,
    input  logic [31:0] weight_in,
    output logic        spike_out,
    output logic [31:0] pot_out
);

    localparam logic [7:0]  SHIFT_E   = 8'(DECAY_SHIFT);
    localparam logic [31:0] NEG_THRESH = {~V_THRESHOLD[31], V_THRESHOLD[30:0]};

    logic [31:0] decayed;
    logic [31:0] sum;
    logic [31:0] remainder;

    // Division by 2^DECAY_SHIFT done purely on the exponent field; small values flush to +0.
    function automatic logic [31:0] fp_decay(input logic [31:0] v);
        if (v[30:23] <= SHIFT_E) begin
            return FP32_ZERO;
        end
        return {v[31], v[30:23] - SHIFT_E, v[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [7:0]  d;
        logic [26:0] mx;
        logic [26:0] my;
        logic [26:0] my_sh;
        logic [26:0] lost_mask;
        logic [27:0] acc;
        logic [24:0] rnd;
        logic [9:0]  er;
        logic        round_up;
        logic [7:0]  exp_f;
        if (fp32_is_nan(a) || fp32_is_nan(b)) begin
            return FP32_QNAN;
        end
        if (fp32_is_inf(a) && fp32_is_inf(b) && (a[31] != b[31])) begin
            return FP32_QNAN;
        end
        if (fp32_is_inf(a)) begin
            return a;
        end
        if (fp32_is_inf(b)) begin
            return b;
        end
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[30:23] == EXP_MIN) ? 8'd1 : x[30:23];
        ey = (y[30:23] == EXP_MIN) ? 8'd1 : y[30:23];
        mx = {(x[30:23] != EXP_MIN), x[22:0], 3'b000};
        my = {(y[30:23] != EXP_MIN), y[22:0], 3'b000};
        d  = ex - ey;
        // Alignment keeps three extra bits (guard, round, sticky) for round-to-nearest-even.
        if (d >= 8'd27) begin
            my_sh = {26'd0, |my};
        end else begin
            lost_mask = (27'd1 << d) - 27'd1;
            my_sh     = (my >> d) | {26'd0, |(my & lost_mask)};
        end
        if (x[31] == y[31]) begin
            acc = {1'b0, mx} + {1'b0, my_sh};
        end else begin
            acc = {1'b0, mx} - {1'b0, my_sh};
        end
        if (acc == 28'd0) begin
            return {x[31] & y[31], 31'd0};
        end
        er = {2'b00, ex};
        if (acc[27]) begin
            acc = {1'b0, acc[27:2], acc[1] | acc[0]};
            er  = er + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!acc[26] && (er > 10'd1)) begin
                    acc = acc << 1;
                    er  = er - 10'd1;
                end
            end
        end
        round_up = acc[2] && (acc[1] || acc[0] || acc[3]);
        rnd      = {1'b0, acc[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            er  = er + 10'd1;
        end
        if (er >= 10'd255) begin
            return {x[31], EXP_MAX, 23'd0};
        end
        exp_f = rnd[23] ? er[7:0] : EXP_MIN;
        return {x[31], exp_f, rnd[22:0]};
    endfunction

    // Strict greater-than; NaN never compares true and +0 equals -0.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (fp32_is_nan(a) || fp32_is_nan(b)) begin
            return 1'b0;
        end
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            return 1'b0;
        end
        if (a[31] != b[31]) begin
            return !a[31];
        end
        if (!a[31]) begin
            return a[30:0] > b[30:0];
        end
        return a[30:0] < b[30:0];
    endfunction

    assign decayed   = fp_decay(pot_in);
    assign sum       = fp_add(decayed, weight_in);
    assign spike_out = fp_gt(sum, V_THRESHOLD);
    assign remainder = fp_add(sum, NEG_THRESH);
    assign pot_out   = spike_out ? remainder : sum;

endmodule

// File: rtl/potential_update_engine.sv
// Time-multiplexed LIF potential update engine: one FP32 datapath serves NUM_NEURONS stored potentials.
// Optional macro POTENTIAL_UPDATE_REFRACTORY_EN adds a one-timestep refractory period after each spike.
module potential_update_engine
    import snn_pkg::*;
#(
    parameter int          NUM_NEURONS = 30,
    parameter logic [31:0] V_THRESHOLD = FP32_DEFAULT_THRESH,
    parameter int          DECAY_SHIFT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_all,
    input  logic                           ts_start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_weight,
    output logic                           out_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] out_idx,
    output logic                           out_spike,
    output logic [31:0]                    out_potential,
    output logic                           busy,
    output logic                           done
);

    localparam int                IDX_W    = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      weight_q, weight_d;
    logic [31:0]      pot_mem_q [NUM_NEURONS];
    logic [31:0]      pot_mem_d [NUM_NEURONS];
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_spike_q, out_spike_d;
    logic [31:0]      out_potential_q, out_potential_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
    logic [NUM_NEURONS-1:0] refr_q, refr_d;
`endif

    logic        dp_spike;
    logic [31:0] dp_pot;

    lif_fp32_datapath #(
        .V_THRESHOLD (V_THRESHOLD),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_datapath (
        .pot_in    (pot_mem_q[idx_q]),
        .weight_in (weight_q),
        .spike_out (dp_spike),
        .pot_out   (dp_pot)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        weight_d        = weight_q;
        pot_mem_d       = pot_mem_q;
        out_valid_d     = 1'b0;
        out_idx_d       = out_idx_q;
        out_spike_d     = out_spike_q;
        out_potential_d = out_potential_q;
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
        refr_d          = refr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ts_start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                if (in_valid && in_ready_q) begin
                    weight_d = in_weight;
                    state_d  = ST_ADD;
                end
            end
            // Result is registered on leaving ADD so it is visible for the whole WRITE cycle.
            ST_ADD: begin
                state_d     = ST_WRITE;
                out_valid_d = 1'b1;
                out_idx_d   = idx_q;
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
                if (refr_q[idx_q]) begin
                    out_spike_d     = 1'b0;
                    out_potential_d = pot_mem_q[idx_q];
                    refr_d[idx_q]   = 1'b0;
                end else begin
                    out_spike_d        = dp_spike;
                    out_potential_d    = dp_pot;
                    pot_mem_d[idx_q]   = dp_pot;
                    refr_d[idx_q]      = dp_spike;
                end
`else
                out_spike_d      = dp_spike;
                out_potential_d  = dp_pot;
                pot_mem_d[idx_q] = dp_pot;
`endif
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_all) begin
            state_d         = ST_IDLE;
            idx_d           = '0;
            out_valid_d     = 1'b0;
            out_idx_d       = '0;
            out_spike_d     = 1'b0;
            out_potential_d = FP32_ZERO;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_mem_d[i] = FP32_ZERO;
            end
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
            refr_d = '0;
`endif
        end

        in_ready_d = (state_d == ST_FETCH);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            in_ready_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_idx_q       <= '0;
            out_spike_q     <= 1'b0;
            out_potential_q <= FP32_ZERO;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_mem_q[i] <= FP32_ZERO;
            end
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
            refr_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            out_idx_q       <= out_idx_d;
            out_spike_q     <= out_spike_d;
            out_potential_q <= out_potential_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pot_mem_q       <= pot_mem_d;
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
            refr_q          <= refr_d;
`endif
        end
    end

    // The latched weight is pure data and needs no reset.
    always_ff @(posedge clk) begin
        weight_q <= weight_d;
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_idx       = out_idx_q;
    assign out_spike     = out_spike_q;
    assign out_potential = out_potential_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_potential_update_engine.sv
// Directed, table-driven bench for potential_update_engine with hand-computed FP32 expectations.
module tb_potential_update_engine;

    localparam int N = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_all = 1'b0;
    logic        ts_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_weight = 32'h0;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        out_spike;
    logic [31:0] out_potential;
    logic        busy;
    logic        done;

    potential_update_engine dut (
        .clk           (clk),
        .rst           (rst),
        .clear_all     (clear_all),
        .ts_start      (ts_start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_weight     (in_weight),
        .out_valid     (out_valid),
        .out_idx       (out_idx),
        .out_spike     (out_spike),
        .out_potential (out_potential),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          stall;
        logic        spk;
        logic [31:0] pot;
    } vec_t;

    vec_t tv [2][N];

    int total = 0;
    int bad = 0;
    int cur_n = -1;
    int done_cnt = 0;
    int ov_cnt = 0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s neuron=%0d actual=%h required=%h", name, cur_n, act, exp);
        end
    endtask

    task automatic setv(input int t, input int n, input logic [31:0] w, input int stall,
                        input logic spk, input logic [31:0] pot);
        tv[t][n].w = w;
        tv[t][n].stall = stall;
        tv[t][n].spk = spk;
        tv[t][n].pot = pot;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_idx"}, 32'(out_idx), 32'h0);
        chk({tag, "_out_spike"}, 32'(out_spike), 32'h0);
        chk({tag, "_out_pot"}, out_potential, 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // Entered and left on a falling edge.
    task automatic start_ts();
        ts_start = 1'b1;
        @(negedge clk);
        ts_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
    endtask

    task automatic run_neuron(input int n, input logic [31:0] w, input int stall,
                              input logic spk, input logic [31:0] pot);
        cur_n = n;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        chk("in_ready_wait", 32'(in_ready), 32'h1);
        for (int k = 0; k < stall; k++) begin
            chk("stall_in_ready", 32'(in_ready), 32'h1);
            chk("stall_out_valid", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_weight = w;
        @(negedge clk);
        in_valid = 1'b0;
        chk("add_in_ready", 32'(in_ready), 32'h0);
        chk("add_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'h1);
        chk("out_idx", 32'(out_idx), 32'(n));
        chk("out_spike", 32'(out_spike), 32'(spk));
        chk("out_pot", out_potential, pot);
        @(negedge clk);
    endtask

    task automatic finish_ts(input int ov_base, input int done_base);
        cur_n = -1;
        chk("done_pulse", 32'(done), 32'h1);
        @(negedge clk);
        chk("busy_end", 32'(busy), 32'h0);
        chk("done_end", 32'(done), 32'h0);
        chk("ov_count", 32'(ov_cnt - ov_base), 32'(N));
        chk("done_count", 32'(done_cnt - done_base), 32'h1);
    endtask

    initial begin
        int ovb;
        int db;

        for (int t = 0; t < 2; t++)
            for (int n = 0; n < N; n++) setv(t, n, 32'h0, 0, 1'b0, 32'h0);
        // First timestep from reset.
        setv(0, 0, 32'h42480000, 0, 1'b1, 32'h41200000);
        setv(0, 1, 32'h42200000, 0, 1'b0, 32'h42200000);
        setv(0, 2, 32'h3F800000, 0, 1'b0, 32'h3F800000);
        setv(0, 3, 32'hC0200000, 0, 1'b0, 32'hC0200000);
        setv(0, 4, 32'h42200001, 0, 1'b1, 32'h36800000);
        setv(0, 5, 32'h42C80000, 0, 1'b1, 32'h42700000);
        setv(0, 7, 32'h3F800000, 5, 1'b0, 32'h3F800000);
        // Second timestep: decayed history plus new weights.
`ifdef POTENTIAL_UPDATE_REFRACTORY_EN
        setv(1, 0, 32'h3F800000, 0, 1'b0, 32'h41200000);
        setv(1, 4, 32'h00000000, 0, 1'b0, 32'h36800000);
        setv(1, 5, 32'h00000000, 0, 1'b0, 32'h42700000);
`else
        setv(1, 0, 32'h3F800000, 0, 1'b0, 32'h40C00000);
        setv(1, 4, 32'h00000000, 0, 1'b0, 32'h36000000);
        setv(1, 5, 32'h00000000, 0, 1'b0, 32'h41F00000);
`endif
        setv(1, 1, 32'h41C80000, 0, 1'b1, 32'h40A00000);
        setv(1, 2, 32'h00000000, 0, 1'b0, 32'h3F000000);
        setv(1, 3, 32'h00000000, 0, 1'b0, 32'hBFA00000);
        setv(1, 6, 32'h7F800000, 0, 1'b1, 32'h7F800000);
        setv(1, 7, 32'h00000000, 0, 1'b0, 32'h3F000000);
        setv(1, 8, 32'hC2200000, 0, 1'b0, 32'hC2200000);
        setv(1, 29, 32'h42200000, 0, 1'b0, 32'h42200000);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        for (int t = 0; t < 2; t++) begin
            ovb = ov_cnt;
            db = done_cnt;
            start_ts();
            for (int n = 0; n < N; n++)
                run_neuron(n, tv[t][n].w, tv[t][n].stall, tv[t][n].spk, tv[t][n].pot);
            finish_ts(ovb, db);
        end

        // Asynchronous reset while neuron 0 is in ADD.
        db = done_cnt;
        start_ts();
        in_valid = 1'b1;
        in_weight = 32'h42480000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        in_valid = 1'b0;
        cur_n = 0;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - db), 32'h0);

        // Array must be zero after reset: neuron 1 would otherwise hold 2.5.
        ovb = ov_cnt;
        db = done_cnt;
        start_ts();
        for (int n = 0; n < N; n++) run_neuron(n, 32'h0, 0, 1'b0, 32'h0);
        finish_ts(ovb, db);

        // clear_all while neuron 12 waits in FETCH.
        db = done_cnt;
        start_ts();
        for (int n = 0; n < 12; n++) run_neuron(n, 32'h3F800000, 0, 1'b0, 32'h3F800000);
        cur_n = 12;
        chk("clear_pre_ready", 32'(in_ready), 32'h1);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check_idle_outputs("clear");
        repeat (4) @(negedge clk);
        chk("clear_no_done", 32'(done_cnt - db), 32'h0);

        ovb = ov_cnt;
        db = done_cnt;
        start_ts();
        for (int n = 0; n < N; n++) run_neuron(n, 32'h0, 0, 1'b0, 32'h0);
        finish_ts(ovb, db);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog neuron=%0d actual=timeout required=finish", cur_n);
        $fatal(1, "watchdog expired");
    end

endmodule
